// File: rtl/lfo_pkg.sv
// Shared constants and types for the DAC frame scheduler: DAC command-word
// fields, midscale value, shutdown word and the scheduler state encoding.
package lfo_pkg;

    localparam int SAMPLE_W = 12;
    localparam int FRAME_W  = 16;

    // DAC command-word header bits (bit15 down to bit12)
    localparam logic FRAME_CH_A       = 1'b0;  // channel A select
    localparam logic FRAME_UNBUF      = 1'b0;  // unbuffered reference
    localparam logic FRAME_GAIN_1X    = 1'b1;  // 1x output gain
    localparam logic FRAME_ENABLE_ON  = 1'b1;  // output active
    localparam logic FRAME_ENABLE_OFF = 1'b0;  // output shut down

    localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'h800;

    localparam logic [FRAME_W-1:0] SHUTDOWN_FRAME =
        {FRAME_CH_A, FRAME_UNBUF, FRAME_GAIN_1X, FRAME_ENABLE_OFF, {SAMPLE_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_SHUTDOWN
    } sched_state_t;

    // Wrap a 12-bit sample into an active channel-A data frame.
    function automatic logic [FRAME_W-1:0] data_frame(input logic [SAMPLE_W-1:0] data);
        return {FRAME_CH_A, FRAME_UNBUF, FRAME_GAIN_1X, FRAME_ENABLE_ON, data};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO with flush. A push into a full FIFO is accepted
// when a pop happens in the same cycle, so the occupancy stays unchanged.
module sample_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W-1:0]           dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign dout    = mem[rd_ptr];

    // Sample storage: data only, never reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Takes waveform samples on wclk edges, buffers them, and hands them one at a
// time to the DAC SPI engine as 16-bit command words using a start/busy
// handshake. Turning the output off flushes the buffer and sends one shutdown
// word once any transfer already on the wire has finished.
module dac_frame_scheduler
    import lfo_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                        CLOCK_50,
    input  logic                        reset_n,
    input  logic                        wclk,
    input  logic [SAMPLE_W-1:0]         sample,
    input  logic                        onOff,
    input  logic                        mute,
    input  logic                        spi_busy,
    output logic                        spi_start,
    output logic [FRAME_W-1:0]          spi_frame,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  drop_cnt,
    output logic                        ack_err
);

    localparam int DATA_W = SAMPLE_W;
    localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    // Saturating increment for the drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              wclk_p0;
    logic              wclk_p1;
    logic              wclk_p2;
    logic              wclk_live;
    logic              wclk_seen_low;
    logic              push_evt;

    logic              onoff_q;
    logic              off_fall;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    sched_state_t      state;
    logic [TMR_W-1:0]  ack_tmr;
    logic              shut_pending;

    // wclk: 2-flop synchroniser (p0, p1) followed by the edge-history flop (p2).
    // wclk_seen_low blocks a false edge when wclk is already high at reset
    // release; wclk_live marks that p0 holds a real sample of wclk.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wclk_p0       <= 1'b0;
            wclk_p1       <= 1'b0;
            wclk_p2       <= 1'b0;
            wclk_live     <= 1'b0;
            wclk_seen_low <= 1'b0;
        end else begin
            wclk_p0       <= wclk;
            wclk_p1       <= wclk_p0;
            wclk_p2       <= wclk_p1;
            wclk_live     <= 1'b1;
            wclk_seen_low <= wclk_seen_low | (wclk_live & ~wclk_p0);
        end
    end

    assign push_evt = wclk_p1 & ~wclk_p2 & wclk_seen_low;

    // onOff history for falling-edge detection
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            onoff_q <= 1'b0;
        end else begin
            onoff_q <= onOff;
        end
    end

    assign off_fall  = onoff_q & ~onOff;
    assign fifo_push = push_evt & onOff;
    assign fifo_pop  = (state == ST_ISSUE) & onOff & ~spi_busy;

    sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (~onOff),
        .din   (sample),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Count samples lost to a full FIFO; a same-cycle pop makes room, so no drop
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= 8'd0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    // Frame issue FSM: registered start pulse and frame word, ack timeout, shutdown
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            spi_start    <= 1'b0;
            spi_frame    <= SHUTDOWN_FRAME;
            ack_tmr      <= '0;
            ack_err      <= 1'b0;
            shut_pending <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            if (off_fall) begin
                shut_pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (shut_pending) begin
                        state <= ST_SHUTDOWN;
                    end else if (!fifo_empty && onOff) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The FIFO was flushed under us; let IDLE send the shutdown word
                    if (!onOff) begin
                        state <= ST_IDLE;
                    end else if (!spi_busy) begin
                        spi_frame <= mute ? data_frame(MIDSCALE) : data_frame(fifo_dout);
                        spi_start <= 1'b1;
                        ack_tmr   <= '0;
                        state     <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (spi_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (ack_tmr == TMR_LAST) begin
                        ack_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        ack_tmr <= ack_tmr + TMR_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!spi_busy) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHUTDOWN: begin
                    if (!spi_busy) begin
                        spi_frame    <= SHUTDOWN_FRAME;
                        spi_start    <= 1'b1;
                        ack_tmr      <= '0;
                        shut_pending <= off_fall;
                        state        <= ST_WAIT_ACK;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Bench for dac_frame_scheduler: an SPI engine model answers spi_start with
// spi_busy, expected frames are queued as samples are driven and checked in
// order whenever the scheduler pulses spi_start.
module tb_dac_frame_scheduler;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b1;
    logic        wclk     = 1'b0;
    logic [11:0] sample   = 12'h000;
    logic        onOff    = 1'b0;
    logic        mute     = 1'b0;
    logic        spi_busy = 1'b0;
    logic        spi_start;
    logic [15:0] spi_frame;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_cnt;
    logic        ack_err;

    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          n_starts  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_f;

    // SPI engine model: 0 = busy 2 cycles after start for busy_len cycles,
    // 1 = never busy, 2 = busy held high
    int          spi_mode  = 0;
    int          busy_len  = 16;
    int          model_cnt = 0;

    dac_frame_scheduler #(
        .FIFO_DEPTH  (4),
        .ACK_TIMEOUT (8)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .wclk       (wclk),
        .sample     (sample),
        .onOff      (onOff),
        .mute       (mute),
        .spi_busy   (spi_busy),
        .spi_start  (spi_start),
        .spi_frame  (spi_frame),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .ack_err    (ack_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (!reset_n) begin
            model_cnt = 0;
            spi_busy  = 1'b0;
        end else if (spi_mode == 2) begin
            model_cnt = 0;
            spi_busy  = 1'b1;
        end else if (spi_mode == 1) begin
            model_cnt = 0;
            spi_busy  = 1'b0;
        end else if (model_cnt > 0) begin
            model_cnt++;
            if (model_cnt == 3) spi_busy = 1'b1;
            else if (model_cnt == 3 + busy_len) begin
                spi_busy  = 1'b0;
                model_cnt = 0;
            end
        end else begin
            spi_busy = 1'b0;
            if (spi_start) model_cnt = 1;
        end
    end

    // Scoreboard: every start pulse must carry the next expected frame
    always @(negedge CLOCK_50) begin
        if (reset_n === 1'b1 && spi_start === 1'b1) begin
            n_starts++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL frame_unexpected: got %h, required no frame", spi_frame);
            end else begin
                exp_f = exp_q.pop_front();
                if (spi_frame !== exp_f) begin
                    n_bad++;
                    $display("FAIL frame_order: got %h, required %h", spi_frame, exp_f);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wclk_pulse(input logic [11:0] s, input int hi, input int lo);
        sample = s;
        wclk   = 1'b1;
        tick(hi);
        wclk   = 1'b0;
        tick(lo);
    endtask

    task automatic wait_drain(input int max_cyc, input string tag);
        bit done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge CLOCK_50);
            if (exp_q.size() == 0 && spi_busy == 1'b0 && spi_start == 1'b0 && model_cnt == 0)
                done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s_drain: %0d frames outstanding after %0d cycles, required 0",
                     tag, exp_q.size(), max_cyc);
        end
        tick(4);
    endtask

    task automatic test_reset;
        #3 reset_n = 1'b0;
        #2;
        n_cmp++; if (spi_start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b, required 0", spi_start); end
        n_cmp++; if (spi_frame !== 16'h2000) begin n_bad++; $display("FAIL rst_frame: got %h, required 2000", spi_frame); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL rst_level: got %0d, required 0", fifo_level); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_drop: got %0d, required 0", drop_cnt); end
        n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL rst_ackerr: got %b, required 0", ack_err); end
        tick(3);
        onOff = 1'b1;
        tick(1);
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_single;
        int base;
        base = n_starts;
        exp_q.push_back(16'h3123);
        wclk_pulse(12'h123, 3, 3);
        wait_drain(80, "single");
        n_cmp++; if (n_starts - base !== 1) begin n_bad++; $display("FAIL single_count: got %0d starts, required 1", n_starts - base); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL single_level: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_overflow;
        int base;
        logic [11:0] s;
        spi_mode = 2;
        tick(2);
        base = n_starts;
        for (int i = 0; i < 6; i++) begin
            s = 12'h010 + 12'(i);
            if (i < 4) exp_q.push_back({4'h3, s});
            wclk_pulse(s, 3, 3);
        end
        tick(3);
        n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL ovf_level: got %0d, required 4", fifo_level); end
        n_cmp++; if (drop_cnt !== 8'd2) begin n_bad++; $display("FAIL ovf_drop: got %0d, required 2", drop_cnt); end
        // push into the full FIFO on the very edge the head is popped
        exp_q.push_back(16'h3016);
        #1;
        sample = 12'h016;
        wclk   = 1'b1;
        @(negedge CLOCK_50);
        #1 spi_mode = 0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL pushpop_level: got %0d, required 4", fifo_level); end
        n_cmp++; if (drop_cnt !== 8'd2) begin n_bad++; $display("FAIL pushpop_drop: got %0d, required 2", drop_cnt); end
        wclk = 1'b0;
        wait_drain(200, "overflow");
        n_cmp++; if (n_starts - base !== 5) begin n_bad++; $display("FAIL ovf_count: got %0d starts, required 5", n_starts - base); end
    endtask

    task automatic test_mute;
        int base;
        mute     = 1'b1;
        spi_mode = 2;
        tick(2);
        base = n_starts;
        exp_q.push_back(16'h3800);
        wclk_pulse(12'hFFF, 3, 3);
        tick(2);
        n_cmp++; if (fifo_level !== 3'd1) begin n_bad++; $display("FAIL mute_level_before: got %0d, required 1", fifo_level); end
        spi_mode = 0;
        wait_drain(80, "mute");
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL mute_level_after: got %0d, required 0", fifo_level); end
        n_cmp++; if (n_starts - base !== 1) begin n_bad++; $display("FAIL mute_count: got %0d starts, required 1", n_starts - base); end
        mute = 1'b0;
    endtask

    task automatic test_shutdown;
        int base;
        busy_len = 30;
        base = n_starts;
        exp_q.push_back(16'h3111);
        wclk_pulse(12'h111, 2, 2);
        wclk_pulse(12'h222, 2, 2);
        wclk_pulse(12'h333, 2, 2);
        wclk_pulse(12'h444, 2, 2);
        tick(2);
        n_cmp++; if (fifo_level !== 3'd3) begin n_bad++; $display("FAIL shdn_queued: got %0d, required 3", fifo_level); end
        n_cmp++; if (spi_busy !== 1'b1) begin n_bad++; $display("FAIL shdn_inflight: busy %b, required 1", spi_busy); end
        onOff = 1'b0;
        exp_q.push_back(16'h2000);
        tick(2);
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL shdn_flush: got %0d, required 0", fifo_level); end
        wait_drain(150, "shutdown");
        tick(10);
        n_cmp++; if (n_starts - base !== 2) begin n_bad++; $display("FAIL shdn_count: got %0d starts, required 2", n_starts - base); end
        onOff = 1'b1;
        tick(10);
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL resume_level: got %0d, required 0", fifo_level); end
        n_cmp++; if (n_starts - base !== 2) begin n_bad++; $display("FAIL resume_count: got %0d starts, required 2", n_starts - base); end
        busy_len = 16;
    endtask

    task automatic test_ack_timeout;
        int  base;
        int  cyc;
        bit  found;
        spi_mode = 1;
        base  = n_starts;
        found = 1'b0;
        cyc   = 0;
        n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL ack_before: got %b, required 0", ack_err); end
        exp_q.push_back(16'h3456);
        sample = 12'h456;
        wclk   = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge CLOCK_50);
            if (spi_start) found = 1'b1;
        end
        wclk = 1'b0;
        n_cmp++; if (!found) begin n_bad++; $display("FAIL ack_start: got no start in 20 cycles, required one"); end
        for (int k = 1; k <= 30 && cyc == 0; k++) begin
            @(negedge CLOCK_50);
            if (ack_err) cyc = k;
        end
        n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL ack_latency: got %0d cycles, required 8", cyc); end
        spi_mode = 0;
        tick(3);
        exp_q.push_back(16'h3789);
        wclk_pulse(12'h789, 3, 3);
        wait_drain(80, "ack");
        n_cmp++; if (n_starts - base !== 2) begin n_bad++; $display("FAIL ack_count: got %0d starts, required 2", n_starts - base); end
        n_cmp++; if (ack_err !== 1'b1) begin n_bad++; $display("FAIL ack_sticky: got %b, required 1", ack_err); end
    endtask

    task automatic test_drop_saturate;
        int base;
        logic [11:0] s;
        spi_mode = 2;
        tick(2);
        base = n_starts;
        for (int i = 0; i < 4; i++) begin
            s = 12'h0A0 + 12'(i);
            exp_q.push_back({4'h3, s});
            wclk_pulse(s, 2, 2);
        end
        for (int i = 0; i < 260; i++) wclk_pulse(12'hBAD, 2, 2);
        tick(3);
        n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL drop_sat: got %0d, required 255", drop_cnt); end
        n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL sat_level: got %0d, required 4", fifo_level); end
        spi_mode = 0;
        wait_drain(300, "saturate");
        n_cmp++; if (n_starts - base !== 4) begin n_bad++; $display("FAIL sat_count: got %0d starts, required 4", n_starts - base); end
    endtask

    task automatic test_reset_mid;
        int base;
        bit found;
        base  = n_starts;
        found = 1'b0;
        exp_q.push_back(16'h30AB);
        sample = 12'h0AB;
        wclk   = 1'b1;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge CLOCK_50);
            if (spi_busy) found = 1'b1;
        end
        wclk = 1'b0;
        n_cmp++; if (!found) begin n_bad++; $display("FAIL midrst_busy: got no busy in 40 cycles, required busy"); end
        tick(2);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (spi_start !== 1'b0) begin n_bad++; $display("FAIL midrst_start: got %b, required 0", spi_start); end
        n_cmp++; if (spi_frame !== 16'h2000) begin n_bad++; $display("FAIL midrst_frame: got %h, required 2000", spi_frame); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL midrst_level: got %0d, required 0", fifo_level); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_drop: got %0d, required 0", drop_cnt); end
        n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL midrst_ackerr: got %b, required 0", ack_err); end
        wclk = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(20);
        n_cmp++; if (n_starts - base !== 1) begin n_bad++; $display("FAIL midrst_spurious: got %0d starts, required 1", n_starts - base); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL midrst_level_after: got %0d, required 0", fifo_level); end
        wclk = 1'b0;
        tick(3);
        exp_q.push_back(16'h30CD);
        wclk_pulse(12'h0CD, 3, 3);
        wait_drain(80, "midrst");
        n_cmp++; if (n_starts - base !== 2) begin n_bad++; $display("FAIL midrst_resume: got %0d starts, required 2", n_starts - base); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_mute();
        test_shutdown();
        test_ack_timeout();
        test_drop_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
